// File: rtl/seq_scan_ctrl_if.sv
// Symbol source stream between a valid/ready source and seq_scan_ctrl.
//   master : the source; drives sym_valid and sym_data, sees sym_ready
//   slave  : the scan controller; sees sym_valid and sym_data, drives sym_ready
interface seq_scan_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  sym_valid;
    logic [DATA_WIDTH-1:0] sym_data;
    logic                  sym_ready;

    modport master (output sym_valid, output sym_data, input  sym_ready);
    modport slave  (input  sym_valid, input  sym_data, output sym_ready);
endinterface

// File: rtl/seq_scan_ctrl.sv
// Frame-level scan controller for the "12131" sequence detector.
// On an accepted start it clears the detector for one cycle, then streams
// exactly frame_len symbols from the source into it. It counts detector
// matches (saturating) and records the index of the symbol that completed
// the first match. A source bubble during the frame aborts it with error.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             scan request, accepted only in IDLE
//   i_frame_len         symbols in the frame, sampled on accepted start
//   o_busy              high in CLEAR, RUN, DRAIN
//   sym_if (slave)      symbol source: sym_valid, sym_data, sym_ready
//   o_det_reset_n       detector reset, registered, low exactly during CLEAR
//   o_det_symbol        detector input symbol, 0 when nothing is accepted
//   i_det_match         detector Moore match output
//   o_done              one-cycle end-of-frame pulse
//   o_error             frame aborted on a bubble, held until next start
//   o_match_count       matches in the last frame, saturating
//   o_match_found       at least one match in the last frame
//   o_first_match_idx   0-based index of the symbol completing the first match
//
// state | meaning
// IDLE  | waiting for start, results held
// CLEAR | detector held in reset for one cycle
// RUN   | one symbol accepted per cycle, bubble aborts
// DRAIN | sample detector response to the last symbol
// DONE  | done pulse, back to IDLE
module seq_scan_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_frame_len,
    output logic                  o_busy,
    seq_scan_ctrl_if.slave        sym_if,
    output logic                  o_det_reset_n,
    output logic [DATA_WIDTH-1:0] o_det_symbol,
    input  logic                  i_det_match,
    output logic                  o_done,
    output logic                  o_error,
    output logic [CNT_WIDTH-1:0]  o_match_count,
    output logic                  o_match_found,
    output logic [LEN_WIDTH-1:0]  o_first_match_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_idx;
    logic                 r_busy;
    logic                 r_det_reset_n;
    logic                 r_done;
    logic                 r_error;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_found;
    logic [LEN_WIDTH-1:0] r_first_idx;

    logic w_run;
    logic w_sample;

    assign w_run = (r_state == S_RUN);

    // The detector output lags its input by one cycle, so det_match belongs to
    // symbol r_idx-1. In DRAIN r_idx has already advanced to r_len.
    assign w_sample = (w_run && (r_idx != '0)) || (r_state == S_DRAIN);

    // Ready depends on state only: the detector has no enable, so we cannot stall.
    assign sym_if.sym_ready = w_run;
    assign o_det_symbol     = (w_run && sym_if.sym_valid) ? sym_if.sym_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_det_reset_n <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_count       <= '0;
            r_found       <= 1'b0;
            r_first_idx   <= '0;
        end else begin
            r_det_reset_n <= 1'b1;
            r_done        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len       <= i_frame_len;
                        r_idx       <= '0;
                        r_error     <= 1'b0;
                        r_count     <= '0;
                        r_found     <= 1'b0;
                        r_first_idx <= '0;
                        if (i_frame_len != '0) begin
                            r_state       <= S_CLEAR;
                            r_det_reset_n <= 1'b0;
                            r_busy        <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (sym_if.sym_valid) begin
                        r_idx <= r_idx + LEN_WIDTH'(1);
                        if (r_idx == r_len - LEN_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Never active in IDLE, so it cannot collide with the result clear above.
            if (w_sample && i_det_match) begin
                if (!(&r_count)) begin
                    r_count <= r_count + CNT_WIDTH'(1);
                end
                if (!r_found) begin
                    r_found     <= 1'b1;
                    r_first_idx <= r_idx - LEN_WIDTH'(1);
                end
            end
        end
    end

    assign o_busy            = r_busy;
    assign o_det_reset_n     = r_det_reset_n;
    assign o_done            = r_done;
    assign o_error           = r_error;
    assign o_match_count     = r_count;
    assign o_match_found     = r_found;
    assign o_first_match_idx = r_first_idx;

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Frame-level scan controller that sequences the `seq` 12131 sequence detector. On `start`, it clears the detector and streams exactly `frame_len` symbols into it from a valid/ready source. It counts detector matches and reports the count, plus the index of the symbol that completed the first match. It is the only block that drives the detector's `reset_n` and `in_symbol`.

Parameters:
- DATA_WIDTH, 8, symbol width. Symbols are ASCII; '1'=0x31, '2'=0x32, '3'=0x33. Must match the detector instance.
- LEN_WIDTH, 8, width of `frame_len` and `first_match_idx`.
- CNT_WIDTH, 8, width of `match_count`.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to scan a frame; accepted only in IDLE.
- frame_len  in  LEN_WIDTH  symbols in the frame; sampled when start is accepted.
- busy  out  1  high in CLEAR, RUN, DRAIN.
- sym_valid  in  1  source symbol valid.
- sym_data  in  DATA_WIDTH  source symbol.
- sym_ready  out  1  controller accepts sym_data this cycle.
- det_reset_n  out  1  to detector `reset_n`; registered.
- det_symbol  out  DATA_WIDTH  to detector `in_symbol`.
- det_match  in  1  from detector `match` (Moore output).
- done  out  1  one-cycle pulse at end of frame.
- error  out  1  frame aborted on source bubble; held until next accepted start.
- match_count  out  CNT_WIDTH  matches in last frame; saturating.
- match_found  out  1  at least one match in last frame.
- first_match_idx  out  LEN_WIDTH  0-based index of the symbol completing the first match.

Behaviour:
- Reset (sync, high): state=IDLE, det_reset_n=0 for the cycle after reset, then 1. busy=done=error=match_found=0, match_count=0, first_match_idx=0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - start && frame_len!=0 -> CLEAR. Latch frame_len; clear error, match_count, match_found, first_match_idx.
  - start && frame_len==0 -> DONE with cleared results.
- CLEAR (1 cycle): det_reset_n=0. The register is set on the IDLE->CLEAR transition, so the pin is low exactly during CLEAR. -> RUN.
- RUN:
  - sym_ready = (state==RUN) — combinational from state only, never from sym_valid.
  - When sym_valid: det_symbol = sym_data combinationally, accept, sym_idx++.
  - After the symbol with index frame_len-1 is accepted -> DRAIN.
  - If !sym_valid in any RUN cycle: set error, -> DONE (abort). No stalling: the detector has no enable, so a bubble invalidates the frame.
- det_symbol = 0 whenever no symbol is being accepted. 0 is a neutral filler; the detector returns to START.
- Match accounting:
  - In RUN cycles with sym_idx>0, det_match reflects symbol sym_idx-1.
  - In DRAIN, det_match reflects the last symbol.
  - When det_match=1 in these cycles: match_count increments, saturating at all-ones.
  - On the first such match: match_found=1 and first_match_idx = index of that symbol.
  - In the abort cycle, det_match for the previously accepted symbol is still counted.
- DRAIN (1 cycle): sample det_match. -> DONE.
- DONE (1 cycle): done=1, busy=0. -> IDLE.
- Results hold from DONE until the next accepted start.
- start outside IDLE (including DONE) is ignored.
- Overlapping matches count. This follows the detector's overlap behaviour: after 12131, the sequence 2131 completes another match.
- Reset mid-operation: immediate return to IDLE, results cleared, detector reset via det_reset_n. No done pulse.
- Latency for frame_len=N with no bubbles: start accepted at cycle 0, CLEAR at 1, RUN at 2..N+1, DRAIN at N+2, done at N+3.

Test Plan:
- Single match: start, frame_len=5, "12131" continuous -> done at cycle 8; match_count=1, match_found=1, first_match_idx=4, error=0. det_reset_n low only in cycle 1.
- Overlap: frame_len=9, "121312131" -> match_count=2, first_match_idx=4.
- No match: frame_len=6, "121321" -> match_count=0, match_found=0, done at cycle 9.
- Bubble: frame_len=5, "12" then sym_valid=0 at the third symbol -> error=1, done the next cycle, match_count=0. sym_ready stays 1 throughout RUN, including the bubble cycle.
- Zero length and ignored start: frame_len=0 -> done at cycle 1, busy never high. start during RUN is ignored; the frame completes normally.
- Saturation and reset: with CNT_WIDTH=2, frame "12131213121312131" (17 symbols, 4 matches) -> match_count=3. Then feed "121", assert reset, start a new frame "31" -> match_count=0 (detector was cleared).
